// File: rtl/mp3_pkg.sv
// Shared types and constants for the MPEG-1 Layer III frame header/side-info packer.
package mp3_pkg;

  localparam logic [10:0] SYNC_WORD       = 11'h7FF;
  localparam logic [1:0]  MPEG1_ID        = 2'b11;
  localparam logic [1:0]  LAYER3_ID       = 2'b01;
  localparam logic [1:0]  MODE_MONO       = 2'b11;
  localparam logic [5:0]  SI_BYTES_MONO   = 6'd17;
  localparam logic [5:0]  SI_BYTES_STEREO = 6'd32;
  localparam logic [8:0]  CRC_BITS_MONO   = 9'd152;
  localparam logic [8:0]  CRC_BITS_STEREO = 9'd272;
  localparam logic [15:0] CRC_POLY        = 16'h8005;
  localparam logic [15:0] CRC_INIT        = 16'hFFFF;

  typedef struct packed {
    logic [1:0]      block_type;
    logic            mixed_block_flag;
    logic [0:1][4:0] table_select;
    logic [0:2][2:0] subblock_gain;
  } gr_ws1_t;

  typedef struct packed {
    logic [0:2][4:0] table_select;
    logic [3:0]      region0_count;
    logic [2:0]      region1_count;
  } gr_ws0_t;

  typedef union packed {
    gr_ws1_t ws1;
    gr_ws0_t ws0;
  } gr_union_t;

  typedef struct packed {
    logic [11:0] part2_3_length;
    logic [8:0]  big_values;
    logic [7:0]  global_gain;
    logic [3:0]  scalefac_compress;
    logic        window_switching_flag;
    gr_union_t   u;
    logic        preflag;
    logic        scalefac_scale;
    logic        count1table_select;
  } gr_ch_info_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CRC  = 3'd1,
    S_HDR  = 3'd2,
    S_CRCB = 3'd3,
    S_SI   = 3'd4
  } pk_state_t;

  // One MSB-first step of the CRC-16 (x^16 + x^15 + x^2 + 1) shift register.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/mp3_crc16_serial.sv
// Bit-serial CRC-16 accumulator; clear has priority over a data step.
module mp3_crc16_serial
  import mp3_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        clear,
  input  logic        enable,
  input  logic        data_bit,
  output logic [15:0] crc
);

  logic [15:0] crc_r;

  // CRC register: re-seed on clear, advance one bit on enable
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      crc_r <= CRC_INIT;
    end else if (clear) begin
      crc_r <= CRC_INIT;
    end else if (enable) begin
      crc_r <= crc16_step(crc_r, data_bit);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/mp3_frame_header_packer.sv
// Packs one MPEG-1 Layer III header + side info (+ optional CRC-16) into an MSB-first byte stream.
module mp3_frame_header_packer
  import mp3_pkg::*;
#(
  parameter bit CRC_EN = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_in_n,
  input  logic              frame_valid_in,
  output logic              frame_ready_out,
  input  logic              prot_n_in,
  input  logic [3:0]        bitrate_idx_in,
  input  logic [1:0]        samp_idx_in,
  input  logic              padding_in,
  input  logic              private_in,
  input  logic [1:0]        mode_in,
  input  logic [1:0]        mode_ext_in,
  input  logic              copyright_in,
  input  logic              original_in,
  input  logic [1:0]        emphasis_in,
  input  logic [8:0]        main_data_begin_in,
  input  logic [4:0]        private_bits_in,
  input  logic [7:0]        scfsi_in,
  input  logic [3:0][58:0]  gr_info_in,
  output logic [7:0]        byte_out,
  output logic              byte_valid_out,
  input  logic              byte_ready_in,
  output logic              byte_last_out
);

  pk_state_t          state_r;
  logic [35:0][7:0]   vec_r;
  logic [287:0]       vec_flat_s;
  logic [287:0]       frame_s;
  logic [31:0]        header_s;
  logic [255:0]       si_s;
  gr_ch_info_t [3:0]  gr_s;
  logic               prot_bit_s;
  logic               protect_s;
  logic               mono_in_s;
  logic               mono_r;
  logic               prot_r;
  logic               crc_lo_r;
  logic               frame_ready_r;
  logic [7:0]         byte_r;
  logic               byte_valid_r;
  logic               byte_last_r;
  logic [5:0]         idx_r;
  logic [5:0]         last_idx_s;
  logic [8:0]         crc_cnt_r;
  logic [8:0]         crc_last_s;
  logic [15:0]        crc_s;
  logic               accept_s;
  logic               take_s;
  logic               crc_en_s;
  logic               crc_bit_s;

  assign gr_s        = gr_info_in;
  assign prot_bit_s  = CRC_EN ? prot_n_in : 1'b1;
  assign protect_s   = CRC_EN && !prot_n_in;
  assign mono_in_s   = (mode_in == MODE_MONO);
  assign accept_s    = frame_valid_in && frame_ready_r;
  assign take_s      = byte_valid_r && byte_ready_in;
  assign vec_flat_s  = vec_r;
  // CRC covers header bits 15:0 onward, i.e. flat bit 271 downwards
  assign crc_bit_s   = vec_flat_s[9'd271 - crc_cnt_r];
  assign crc_en_s    = (state_r == S_CRC);
  assign last_idx_s  = mono_r ? (6'd3 + SI_BYTES_MONO) : (6'd3 + SI_BYTES_STEREO);
  assign crc_last_s  = mono_r ? (CRC_BITS_MONO - 9'd1) : (CRC_BITS_STEREO - 9'd1);

  // Left-aligned header + side-info vector; mono drops the ch1 fields and pads with zeros
  always_comb begin
    header_s = {SYNC_WORD, MPEG1_ID, LAYER3_ID, prot_bit_s, bitrate_idx_in, samp_idx_in,
                padding_in, private_in, mode_in, mode_ext_in, copyright_in, original_in,
                emphasis_in};
    if (mono_in_s) begin
      si_s = {main_data_begin_in, private_bits_in, scfsi_in[7:4], gr_s[0], gr_s[2], 120'h0};
    end else begin
      si_s = {main_data_begin_in, private_bits_in[2:0], scfsi_in,
              gr_s[0], gr_s[1], gr_s[2], gr_s[3]};
    end
    frame_s = {header_s, si_s};
  end

  generate
    if (CRC_EN) begin : g_crc
      mp3_crc16_serial u_crc (
        .clk_in   (clk_in),
        .rst_in_n (rst_in_n),
        .clear    (accept_s),
        .enable   (crc_en_s),
        .data_bit (crc_bit_s),
        .crc      (crc_s)
      );
    end else begin : g_no_crc
      assign crc_s = CRC_INIT;
    end
  endgenerate

  // Frame FSM; the output byte register always holds the byte currently offered downstream
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_r       <= S_IDLE;
      frame_ready_r <= 1'b1;
      byte_r        <= 8'h00;
      byte_valid_r  <= 1'b0;
      byte_last_r   <= 1'b0;
      vec_r         <= '0;
      mono_r        <= 1'b0;
      prot_r        <= 1'b0;
      crc_lo_r      <= 1'b0;
      idx_r         <= 6'd0;
      crc_cnt_r     <= 9'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            vec_r         <= frame_s;
            mono_r        <= mono_in_s;
            prot_r        <= protect_s;
            frame_ready_r <= 1'b0;
            crc_cnt_r     <= 9'd0;
            crc_lo_r      <= 1'b0;
            if (protect_s) begin
              state_r <= S_CRC;
            end else begin
              state_r      <= S_HDR;
              byte_r       <= frame_s[287:280];
              byte_valid_r <= 1'b1;
              idx_r        <= 6'd1;
            end
          end
        end
        S_CRC: begin
          if (crc_cnt_r == crc_last_s) begin
            state_r      <= S_HDR;
            byte_r       <= vec_r[35];
            byte_valid_r <= 1'b1;
            idx_r        <= 6'd1;
          end else begin
            crc_cnt_r <= crc_cnt_r + 9'd1;
          end
        end
        S_HDR: begin
          if (take_s) begin
            if (idx_r == 6'd4) begin
              if (prot_r) begin
                state_r <= S_CRCB;
                byte_r  <= crc_s[15:8];
              end else begin
                state_r <= S_SI;
                byte_r  <= vec_r[31];
                idx_r   <= 6'd5;
              end
            end else begin
              byte_r <= vec_r[6'd35 - idx_r];
              idx_r  <= idx_r + 6'd1;
            end
          end
        end
        S_CRCB: begin
          if (take_s) begin
            if (!crc_lo_r) begin
              byte_r   <= crc_s[7:0];
              crc_lo_r <= 1'b1;
            end else begin
              state_r <= S_SI;
              byte_r  <= vec_r[31];
              idx_r   <= 6'd5;
            end
          end
        end
        S_SI: begin
          if (take_s) begin
            if (byte_last_r) begin
              state_r       <= S_IDLE;
              byte_r        <= 8'h00;
              byte_valid_r  <= 1'b0;
              byte_last_r   <= 1'b0;
              frame_ready_r <= 1'b1;
            end else begin
              byte_r      <= vec_r[6'd35 - idx_r];
              byte_last_r <= (idx_r == last_idx_s);
              idx_r       <= idx_r + 6'd1;
            end
          end
        end
        default: begin
          state_r       <= S_IDLE;
          byte_r        <= 8'h00;
          byte_valid_r  <= 1'b0;
          byte_last_r   <= 1'b0;
          frame_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign frame_ready_out = frame_ready_r;
  assign byte_out        = byte_r;
  assign byte_valid_out  = byte_valid_r;
  assign byte_last_out   = byte_last_r;

endmodule

// File: tb/tb_mp3_frame_header_packer.sv
// Directed self-checking bench for mp3_frame_header_packer: framing, CRC, stalls, back-to-back, reset.
module tb_mp3_frame_header_packer;

  logic             clk_in = 1'b0;
  logic             rst_in_n;
  logic             frame_valid_in;
  logic             frame_ready_out;
  logic             prot_n_in;
  logic [3:0]       bitrate_idx_in;
  logic [1:0]       samp_idx_in;
  logic             padding_in;
  logic             private_in;
  logic [1:0]       mode_in;
  logic [1:0]       mode_ext_in;
  logic             copyright_in;
  logic             original_in;
  logic [1:0]       emphasis_in;
  logic [8:0]       main_data_begin_in;
  logic [4:0]       private_bits_in;
  logic [7:0]       scfsi_in;
  logic [3:0][58:0] gr_info;
  logic [7:0]       byte_out;
  logic             byte_valid_out;
  logic             byte_ready_in;
  logic             byte_last_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] cap   [0:63];
  logic [7:0] exp_b [0:63];
  int         cap_n, exp_n, lat, last_cnt, last_pos, stab_err, fr_err, acc_wait;
  logic [15:0] exp_crc;
  bit          sb[$];

  always #5 clk_in = ~clk_in;

  mp3_frame_header_packer dut (
    .clk_in             (clk_in),
    .rst_in_n           (rst_in_n),
    .frame_valid_in     (frame_valid_in),
    .frame_ready_out    (frame_ready_out),
    .prot_n_in          (prot_n_in),
    .bitrate_idx_in     (bitrate_idx_in),
    .samp_idx_in        (samp_idx_in),
    .padding_in         (padding_in),
    .private_in         (private_in),
    .mode_in            (mode_in),
    .mode_ext_in        (mode_ext_in),
    .copyright_in       (copyright_in),
    .original_in        (original_in),
    .emphasis_in        (emphasis_in),
    .main_data_begin_in (main_data_begin_in),
    .private_bits_in    (private_bits_in),
    .scfsi_in           (scfsi_in),
    .gr_info_in         (gr_info),
    .byte_out           (byte_out),
    .byte_valid_out     (byte_valid_out),
    .byte_ready_in      (byte_ready_in),
    .byte_last_out      (byte_last_out)
  );

  task automatic set_zero();
    prot_n_in = 1'b1; bitrate_idx_in = 4'd0; samp_idx_in = 2'd0; padding_in = 1'b0;
    private_in = 1'b0; mode_in = 2'd0; mode_ext_in = 2'd0; copyright_in = 1'b0;
    original_in = 1'b0; emphasis_in = 2'd0; main_data_begin_in = 9'd0;
    private_bits_in = 5'd0; scfsi_in = 8'd0;
    for (int i = 0; i < 4; i++) gr_info[i] = 59'd0;
  endtask

  task automatic rand_fields(input bit mono);
    bitrate_idx_in = 4'($urandom); samp_idx_in = 2'($urandom); padding_in = 1'($urandom);
    private_in = 1'($urandom); mode_ext_in = 2'($urandom); copyright_in = 1'($urandom);
    original_in = 1'($urandom); emphasis_in = 2'($urandom);
    mode_in = mono ? 2'b11 : 2'($urandom_range(0, 2));
    main_data_begin_in = 9'($urandom); private_bits_in = 5'($urandom); scfsi_in = 8'($urandom);
    for (int i = 0; i < 4; i++) gr_info[i] = 59'({$urandom, $urandom});
  endtask

  task automatic push_bits(input logic [63:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) sb.push_back(v[i]);
  endtask

  function automatic logic [15:0] sw_crc_bit(input logic [15:0] c, input bit d);
    logic msb;
    msb = c[15];
    c = c << 1;
    if (msb != d) c = c ^ 16'h8005;
    return c;
  endfunction

  // Golden packer: field-by-field bit stream, software CRC, CRC bytes spliced after the header
  task automatic build_expected();
    logic [15:0] c;
    logic [7:0]  bv;
    bit          mono;
    sb.delete();
    mono = (mode_in == 2'b11);
    push_bits(64'h7FF, 11); push_bits(64'h3, 2); push_bits(64'h1, 2);
    push_bits(64'(prot_n_in), 1); push_bits(64'(bitrate_idx_in), 4);
    push_bits(64'(samp_idx_in), 2); push_bits(64'(padding_in), 1);
    push_bits(64'(private_in), 1); push_bits(64'(mode_in), 2);
    push_bits(64'(mode_ext_in), 2); push_bits(64'(copyright_in), 1);
    push_bits(64'(original_in), 1); push_bits(64'(emphasis_in), 2);
    push_bits(64'(main_data_begin_in), 9);
    if (mono) begin
      push_bits(64'(private_bits_in), 5); push_bits(64'(scfsi_in[7:4]), 4);
      push_bits(64'(gr_info[0]), 59); push_bits(64'(gr_info[2]), 59);
    end else begin
      push_bits(64'(private_bits_in[2:0]), 3); push_bits(64'(scfsi_in), 8);
      for (int g = 0; g < 4; g++) push_bits(64'(gr_info[g]), 59);
    end
    c = 16'hFFFF;
    for (int i = 16; i < sb.size(); i++) c = sw_crc_bit(c, sb[i]);
    exp_crc = c;
    exp_n = 0;
    for (int k = 0; k < sb.size() / 8; k++) begin
      if (k == 4 && !prot_n_in) begin
        exp_b[exp_n] = c[15:8]; exp_b[exp_n + 1] = c[7:0]; exp_n += 2;
      end
      for (int j = 0; j < 8; j++) bv[7 - j] = sb[k * 8 + j];
      exp_b[exp_n] = bv; exp_n++;
    end
  endtask

  function automatic logic [15:0] cap_bits(input int start, input int len);
    logic [15:0] v;
    v = 16'd0;
    for (int i = 0; i < len; i++) v = {v[14:0], cap[(start + i) / 8][7 - ((start + i) % 8)]};
    return v;
  endfunction

  // Offers the current fields, records accepted bytes and protocol observations (no checking here)
  task automatic capture(input int rmode, input bit hold, input bit scramble);
    int  cyc, stall_cnt;
    bit  done, prev_stall, r;
    logic [7:0] pb;
    logic pl;
    cap_n = 0; lat = -1; last_cnt = 0; last_pos = -1; stab_err = 0; fr_err = 0;
    frame_valid_in = 1'b1;
    acc_wait = 0;
    while (frame_ready_out !== 1'b1 && acc_wait < 50) begin
      @(negedge clk_in); acc_wait++;
    end
    cyc = 0; done = 0; prev_stall = 0; stall_cnt = 0; pb = 8'h00; pl = 1'b0;
    while (!done && cyc < 1000) begin
      @(negedge clk_in); cyc++;
      if (cyc == 1) begin
        if (!hold) frame_valid_in = 1'b0;
        if (scramble) begin rand_fields(1'($urandom)); prot_n_in = 1'($urandom); end
      end
      if (frame_ready_out !== 1'b0) fr_err++;
      if (prev_stall && (byte_out !== pb || byte_valid_out !== 1'b1 || byte_last_out !== pl))
        stab_err++;
      if (byte_valid_out === 1'b1 && lat < 0) lat = cyc;
      if (rmode == 0) r = 1'b1;
      else if (cap_n == 5 && stall_cnt < 20) begin r = 1'b0; stall_cnt++; end
      else r = 1'($urandom_range(0, 1));
      byte_ready_in = r;
      if (byte_valid_out === 1'b1) begin
        if (r) begin
          cap[cap_n] = byte_out;
          if (byte_last_out === 1'b1) begin last_cnt++; last_pos = cap_n; done = 1; end
          cap_n++;
          if (cap_n > 60) done = 1;
        end
        prev_stall = !r; pb = byte_out; pl = byte_last_out;
      end else begin
        prev_stall = 0;
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (frame_ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_frame_ready: got %b want 1", frame_ready_out); end
    n_cmp++; if (byte_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_byte_valid: got %b want 0", byte_valid_out); end
    n_cmp++; if (byte_last_out !== 1'b0) begin n_bad++; $display("FAIL reset_byte_last: got %b want 0", byte_last_out); end
    n_cmp++; if (byte_out !== 8'h00) begin n_bad++; $display("FAIL reset_byte: got %h want 00", byte_out); end
  endtask

  task automatic test_mono_unprot();
    logic [7:0] k6 [0:5];
    k6[0] = 8'hFF; k6[1] = 8'hFB; k6[2] = 8'h90; k6[3] = 8'hC0; k6[4] = 8'hFF; k6[5] = 8'h80;
    set_zero(); bitrate_idx_in = 4'd9; mode_in = 2'b11; main_data_begin_in = 9'h1FF;
    build_expected();
    capture(0, 1'b0, 1'b1);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL mono_latency: got %0d want 1", lat); end
    n_cmp++; if (cap_n !== 21) begin n_bad++; $display("FAIL mono_count: got %0d want 21", cap_n); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (cap[i] !== k6[i]) begin n_bad++; $display("FAIL mono_byte%0d: got %h want %h", i, cap[i], k6[i]); end
    end
    for (int i = 6; i < 21; i++) begin
      n_cmp++; if (cap[i] !== exp_b[i]) begin n_bad++; $display("FAIL mono_golden%0d: got %h want %h", i, cap[i], exp_b[i]); end
    end
    n_cmp++; if (last_cnt !== 1 || last_pos !== 20) begin n_bad++; $display("FAIL mono_last: got cnt %0d pos %0d want 1/20", last_cnt, last_pos); end
    n_cmp++; if (fr_err !== 0) begin n_bad++; $display("FAIL mono_ready_low: got %0d violations want 0", fr_err); end
    @(negedge clk_in);
    n_cmp++; if (frame_ready_out !== 1'b1 || byte_valid_out !== 1'b0) begin n_bad++; $display("FAIL mono_idle_after: got rdy %b vld %b want 1/0", frame_ready_out, byte_valid_out); end
  endtask

  task automatic test_stereo_crc();
    set_zero(); rand_fields(1'b0); prot_n_in = 1'b0;
    build_expected();
    capture(0, 1'b0, 1'b1);
    n_cmp++; if (lat !== 273) begin n_bad++; $display("FAIL stereo_latency: got %0d want 273", lat); end
    n_cmp++; if (cap_n !== 38) begin n_bad++; $display("FAIL stereo_count: got %0d want 38", cap_n); end
    n_cmp++; if (cap[1] !== 8'hFA) begin n_bad++; $display("FAIL stereo_prot_byte: got %h want fa", cap[1]); end
    n_cmp++; if ({cap[4], cap[5]} !== exp_crc) begin n_bad++; $display("FAIL stereo_crc: got %h%h want %h", cap[4], cap[5], exp_crc); end
    for (int i = 0; i < 38; i++) begin
      n_cmp++; if (cap[i] !== exp_b[i]) begin n_bad++; $display("FAIL stereo_golden%0d: got %h want %h", i, cap[i], exp_b[i]); end
    end
    n_cmp++; if (last_cnt !== 1 || last_pos !== 37) begin n_bad++; $display("FAIL stereo_last: got cnt %0d pos %0d want 1/37", last_cnt, last_pos); end
    @(negedge clk_in);
  endtask

  task automatic test_ws_roundtrip();
    set_zero(); mode_in = 2'b11; main_data_begin_in = 9'h0A5;
    gr_info[0] = {12'hABC, 9'h155, 8'h9D, 4'h6, 1'b1, 2'b10, 1'b1, 5'h11, 5'h0E,
                  3'h5, 3'h2, 3'h7, 1'b1, 1'b0, 1'b1};
    gr_info[2] = {12'h123, 9'h0AA, 8'h42, 4'h9, 1'b0, 5'h1F, 5'h03, 5'h15,
                  4'hC, 3'h5, 1'b0, 1'b1, 1'b0};
    gr_info[1] = {59{1'b1}}; gr_info[3] = {59{1'b1}};
    build_expected();
    capture(0, 1'b0, 1'b1);
    n_cmp++; if (cap_n !== 21) begin n_bad++; $display("FAIL ws_count: got %0d want 21", cap_n); end
    n_cmp++; if (cap[6] !== 8'h2A) begin n_bad++; $display("FAIL ws_byte6: got %h want 2a", cap[6]); end
    for (int i = 0; i < 21; i++) begin
      n_cmp++; if (cap[i] !== exp_b[i]) begin n_bad++; $display("FAIL ws_golden%0d: got %h want %h", i, cap[i], exp_b[i]); end
    end
    n_cmp++; if (cap_bits(32, 9) !== 16'h0A5) begin n_bad++; $display("FAIL rt_mdb: got %h want 0a5", cap_bits(32, 9)); end
    n_cmp++; if (cap_bits(50, 12) !== 16'hABC) begin n_bad++; $display("FAIL rt_p23: got %h want abc", cap_bits(50, 12)); end
    n_cmp++; if (cap_bits(84, 2) !== 16'h2) begin n_bad++; $display("FAIL rt_block_type: got %h want 2", cap_bits(84, 2)); end
    n_cmp++; if (cap_bits(92, 5) !== 16'h0E) begin n_bad++; $display("FAIL rt_ws1_ts1: got %h want 0e", cap_bits(92, 5)); end
    n_cmp++; if (cap_bits(103, 3) !== 16'h7) begin n_bad++; $display("FAIL rt_sbg2: got %h want 7", cap_bits(103, 3)); end
    n_cmp++; if (cap_bits(142, 1) !== 16'h0) begin n_bad++; $display("FAIL rt_ws_flag: got %h want 0", cap_bits(142, 1)); end
    n_cmp++; if (cap_bits(153, 5) !== 16'h15) begin n_bad++; $display("FAIL rt_ws0_ts2: got %h want 15", cap_bits(153, 5)); end
    n_cmp++; if (cap_bits(158, 4) !== 16'hC) begin n_bad++; $display("FAIL rt_region0: got %h want c", cap_bits(158, 4)); end
    n_cmp++; if (cap_bits(162, 3) !== 16'h5) begin n_bad++; $display("FAIL rt_region1: got %h want 5", cap_bits(162, 3)); end
    n_cmp++; if (cap_bits(166, 1) !== 16'h1) begin n_bad++; $display("FAIL rt_sf_scale: got %h want 1", cap_bits(166, 1)); end
    @(negedge clk_in);
  endtask

  task automatic test_stall();
    set_zero(); rand_fields(1'b1); prot_n_in = 1'b0;
    build_expected();
    capture(1, 1'b0, 1'b1);
    n_cmp++; if (lat !== 153) begin n_bad++; $display("FAIL stall_latency: got %0d want 153", lat); end
    n_cmp++; if (cap_n !== 23) begin n_bad++; $display("FAIL stall_count: got %0d want 23", cap_n); end
    for (int i = 0; i < 23; i++) begin
      n_cmp++; if (cap[i] !== exp_b[i]) begin n_bad++; $display("FAIL stall_golden%0d: got %h want %h", i, cap[i], exp_b[i]); end
    end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes want 0", stab_err); end
    n_cmp++; if (fr_err !== 0) begin n_bad++; $display("FAIL stall_ready_low: got %0d violations want 0", fr_err); end
    n_cmp++; if (last_cnt !== 1 || last_pos !== 22) begin n_bad++; $display("FAIL stall_last: got cnt %0d pos %0d want 1/22", last_cnt, last_pos); end
    byte_ready_in = 1'b1;
    @(negedge clk_in);
    n_cmp++; if (frame_ready_out !== 1'b1) begin n_bad++; $display("FAIL stall_ready_after: got %b want 1", frame_ready_out); end
  endtask

  task automatic test_back_to_back();
    set_zero(); rand_fields(1'b0); prot_n_in = 1'b1;
    build_expected();
    capture(0, 1'b1, 1'b0);
    n_cmp++; if (cap_n !== 36) begin n_bad++; $display("FAIL b2b_count_a: got %0d want 36", cap_n); end
    capture(0, 1'b1, 1'b0);
    frame_valid_in = 1'b0;
    n_cmp++; if (acc_wait !== 1) begin n_bad++; $display("FAIL b2b_accept_gap: got %0d cycles want 1", acc_wait); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL b2b_latency: got %0d want 1", lat); end
    n_cmp++; if (cap_n !== 36) begin n_bad++; $display("FAIL b2b_count_b: got %0d want 36", cap_n); end
    for (int i = 0; i < 36; i++) begin
      n_cmp++; if (cap[i] !== exp_b[i]) begin n_bad++; $display("FAIL b2b_golden%0d: got %h want %h", i, cap[i], exp_b[i]); end
    end
    @(negedge clk_in);
    @(negedge clk_in);
    n_cmp++; if (byte_valid_out !== 1'b0 || frame_ready_out !== 1'b1) begin n_bad++; $display("FAIL b2b_no_third: got vld %b rdy %b want 0/1", byte_valid_out, frame_ready_out); end
  endtask

  task automatic test_reset_mid();
    int seen, cyc;
    set_zero(); bitrate_idx_in = 4'd9; mode_in = 2'b11; main_data_begin_in = 9'h1FF;
    frame_valid_in = 1'b1;
    byte_ready_in  = 1'b1;
    seen = 0; cyc = 0;
    while (seen < 10 && cyc < 100) begin
      @(negedge clk_in); cyc++;
      frame_valid_in = 1'b0;
      if (byte_valid_out === 1'b1) seen++;
    end
    #2 rst_in_n = 1'b0;
    #1;
    n_cmp++; if (byte_valid_out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", byte_valid_out); end
    n_cmp++; if (byte_last_out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_last: got %b want 0", byte_last_out); end
    n_cmp++; if (byte_out !== 8'h00) begin n_bad++; $display("FAIL mid_rst_byte: got %h want 00", byte_out); end
    n_cmp++; if (frame_ready_out !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 1", frame_ready_out); end
    @(negedge clk_in);
    rst_in_n = 1'b1;
    @(negedge clk_in);
    build_expected();
    capture(0, 1'b0, 1'b0);
    n_cmp++; if (cap[0] !== 8'hFF || cap[1] !== 8'hFB) begin n_bad++; $display("FAIL mid_rst_sync: got %h %h want ff fb", cap[0], cap[1]); end
    n_cmp++; if (cap_n !== 21) begin n_bad++; $display("FAIL mid_rst_count: got %0d want 21", cap_n); end
    for (int i = 2; i < 21; i++) begin
      n_cmp++; if (cap[i] !== exp_b[i]) begin n_bad++; $display("FAIL mid_rst_golden%0d: got %h want %h", i, cap[i], exp_b[i]); end
    end
    @(negedge clk_in);
  endtask

  initial begin
    rst_in_n = 1'b0;
    frame_valid_in = 1'b0;
    byte_ready_in = 1'b0;
    set_zero();
    repeat (3) @(negedge clk_in);
    test_reset();
    rst_in_n = 1'b1;
    @(negedge clk_in);
    test_reset();
    test_mono_unprot();
    test_stereo_crc();
    test_ws_roundtrip();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
